// File: rtl/nrisc_int_ctrl.sv
// nrisc_int_ctrl: prioritised interrupt controller for the NRISC core.
// Rising edges on the peripheral lines are latched into a pending register.
// A mask and a global enable select the eligible channels, and the lowest
// eligible index is offered to the core. The REQ / SERVICE handshake tracks
// acknowledge and return-from-interrupt.
module nrisc_int_ctrl #(
   parameter int TAM  = 16,
   parameter int N_CH = 8,
   parameter int CH_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] irq_in,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [TAM-1:0]  cfg_wdata,
   output logic [TAM-1:0]  cfg_rdata,
   output logic            INTERRUPT_flag,
   output logic [7:0]      INTERRUPT_ch,
   input  logic            int_ack,
   input  logic            int_done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N_CH-1:0] irq_d_q;
   logic [N_CH-1:0] pend_q, pend_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic            gen_q, gen_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic            flag_q, flag_d;

   logic            wr_mask_s, wr_pend_s, wr_ctrl_s;
   logic [N_CH-1:0] rise_s;
   logic [N_CH-1:0] w1c_s;
   logic [N_CH-1:0] ack_clr_s;
   logic [N_CH-1:0] elig_s;
   logic [CH_W-1:0] win_s;
   logic            any_elig_s;
   logic            ack_take_s;

   // Upper write-data bits have no register behind them.
   logic            unused_wdata_s;
   assign unused_wdata_s = ^cfg_wdata[TAM-1:N_CH];

   // Register-port write decode and next values of the configuration registers.
   always_comb begin
      wr_mask_s = cfg_we && (cfg_addr == 2'd0);
      wr_pend_s = cfg_we && (cfg_addr == 2'd1);
      wr_ctrl_s = cfg_we && (cfg_addr == 2'd2);
      mask_d    = wr_mask_s ? cfg_wdata[N_CH-1:0] : mask_q;
      gen_d     = wr_ctrl_s ? cfg_wdata[0] : gen_q;
   end

   // Pending update: new rising edges override W1C and acknowledge clears.
   always_comb begin
      rise_s    = irq_in & ~irq_d_q;
      w1c_s     = wr_pend_s ? cfg_wdata[N_CH-1:0] : {N_CH{1'b0}};
      ack_clr_s = ack_take_s ? (N_CH'(1) << ch_q) : {N_CH{1'b0}};
      pend_d    = (pend_q & ~(w1c_s | ack_clr_s)) | rise_s;
   end

   // Fixed-priority arbiter: scanning downwards leaves the lowest index.
   always_comb begin
      elig_s     = pend_q & mask_q & {N_CH{gen_q}};
      any_elig_s = |elig_s;
      win_s      = {CH_W{1'b0}};
      for (int i = N_CH - 1; i >= 0; i--) begin
         win_s = elig_s[i] ? CH_W'(i) : win_s;
      end
   end

   // Handshake FSM next state, latched channel and registered request flag.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      flag_d     = 1'b0;
      ack_take_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_elig_s) begin
               state_d = ST_REQ;
               ch_d    = win_s;
               flag_d  = 1'b1;
            end else begin
               ch_d    = {CH_W{1'b0}};
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               // Acknowledge wins over a simultaneous withdrawal.
               ack_take_s = 1'b1;
               state_d    = ST_SERVICE;
            end else if (!mask_d[ch_q] || !gen_d) begin
               // Withdraw; the pending bit stays for a later retry.
               state_d = ST_IDLE;
               ch_d    = {CH_W{1'b0}};
            end else begin
               flag_d  = 1'b1;
            end
         end
         ST_SERVICE: begin
            if (int_done) begin
               state_d = ST_IDLE;
               ch_d    = {CH_W{1'b0}};
            end else begin
               state_d = ST_SERVICE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ch_d    = {CH_W{1'b0}};
         end
      endcase
   end

   // State and register storage with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         irq_d_q <= {N_CH{1'b0}};
         pend_q  <= {N_CH{1'b0}};
         mask_q  <= {N_CH{1'b0}};
         gen_q   <= 1'b0;
         ch_q    <= {CH_W{1'b0}};
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_d_q <= irq_in;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         gen_q   <= gen_d;
         ch_q    <= ch_d;
         flag_q  <= flag_d;
      end
   end

   // Combinational register read-back; unused bits read as zero.
   always_comb begin
      cfg_rdata = {TAM{1'b0}};
      case (cfg_addr)
         2'd0: cfg_rdata[N_CH-1:0] = mask_q;
         2'd1: cfg_rdata[N_CH-1:0] = pend_q;
         2'd2: cfg_rdata[0]        = gen_q;
         2'd3: begin
            cfg_rdata[15]       = (state_q != ST_IDLE);
            cfg_rdata[14]       = (state_q == ST_SERVICE);
            cfg_rdata[CH_W-1:0] = ch_q;
         end
         default: cfg_rdata = {TAM{1'b0}};
      endcase
   end

   assign INTERRUPT_flag = flag_q;
   assign INTERRUPT_ch   = {{(8-CH_W){1'b0}}, ch_q};

endmodule

// File: doc/nrisc_int_ctrl.md
Name: nrisc_int_ctrl

Overview:
Prioritised interrupt controller for the NRISC core. Latches rising edges on up to 8 peripheral interrupt lines into a pending register and applies a mask and a global enable. Presents one channel at a time to the core on INTERRUPT_flag/INTERRUPT_ch and tracks acknowledge and return-from-interrupt. The core configures and inspects it through a small register port on the data bus.

Parameters:
TAM, 16, data-bus width in bits for the register port.
N_CH, 8, number of interrupt channels; the allowed range is 1..8.
CH_W, 3, width of the channel index.

Ports:
clk  in  1  main clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
irq_in  in  N_CH  peripheral interrupt lines, level in, edge-detected, already synchronous to clk.
cfg_we  in  1  register write strobe.
cfg_addr  in  2  register select.
cfg_wdata  in  TAM  register write data.
cfg_rdata  out  TAM  register read data, combinational from cfg_addr.
INTERRUPT_flag  out  1  interrupt request to the core.
INTERRUPT_ch  out  8  index of the active channel, zero-extended.
int_ack  in  1  one-cycle pulse from the core: request taken.
int_done  in  1  one-cycle pulse from the core: handler returned.

Behaviour:
- Reset, while rst=1 at a clock edge:
  - irq_d, pend, mask and gen are cleared to 0; state is IDLE.
  - INTERRUPT_flag=0, INTERRUPT_ch=0, active channel=0.
  - cfg_rdata follows the reset register contents.
  - Reset applied mid-REQ or mid-SERVICE aborts the sequence, and pending edges are lost.
- Edge detect:
  - irq_d <= irq_in every cycle.
  - pend[i] is set on any edge where irq_in[i]=1 and irq_d[i]=0.
  - Pending is set regardless of mask and gen.
- Eligible set = pend & mask, qualified by gen.
  - Fixed priority: the lowest index wins.
- Register map:
  - Addr 0, MASK[N_CH-1:0]: read/write.
  - Addr 1, PEND: read; writing 1 to a bit clears it.
  - Addr 2, CTRL: bit0 is gen, the global enable; read/write.
  - Addr 3, STATUS (read-only): bit15 = state!=IDLE; bit14 = state==SERVICE; bits[CH_W-1:0] = active channel.
  - Unused bits read 0. Writes to address 3 are ignored.
- Pending-bit conflicts:
  - A set and a clear (W1C or ack) on the same bit in the same cycle: set wins.
- FSM, states IDLE / REQ / SERVICE:
  - IDLE: if any channel is eligible, latch the winning index, go to REQ, and register INTERRUPT_flag=1 with INTERRUPT_ch=index.
    - Latency: irq_in rises before edge k, pend is visible after edge k, and the flag is high after edge k+1.
  - REQ: INTERRUPT_flag and INTERRUPT_ch are held stable. A higher-priority arrival does not change the channel.
    - int_ack=1: clear pend[ch], go to SERVICE, flag drops after the same edge.
    - Otherwise, if mask[ch]=0 or gen=0 (including via a same-cycle cfg write): withdraw. Flag drops, go to IDLE, and pend[ch] is kept.
    - int_ack has priority over withdrawal.
  - SERVICE: INTERRUPT_flag=0 and INTERRUPT_ch holds the channel. There is no nesting; new edges only accumulate in pend.
    - int_done=1: go to IDLE. Re-arbitration is allowed on the next edge, so the minimum gap between flags is 1 idle cycle.
- Stray handshakes:
  - int_ack outside REQ is ignored.
  - int_done outside SERVICE is ignored.
- A channel whose line stays high produces one pending edge only; it must fall and rise again to re-pend.
- Channels at or above N_CH do not exist. Their bits read 0 and writes to them are ignored.

Test Plan:
- Reset, then read all registers -> all read 0, flag=0. Write MASK=0x00FF, CTRL=1, pulse irq_in[3] -> PEND=0x0008 after 1 edge, flag=1 and ch=3 one edge later. Pulse int_ack -> PEND=0, STATUS=0xC003. Pulse int_done -> STATUS=0.
- irq_in[5] and irq_in[2] rise in the same cycle, MASK=0xFF -> ch=2 first. After ack/done and 1 cycle, ch=5.
- MASK=0xFE, irq_in[0] rises -> PEND bit0=1, flag stays 0. Write MASK=0xFF -> flag=1, ch=0 on the next edge.
- In REQ on ch4, write CTRL=0 -> flag=0 next edge, state IDLE, PEND bit4 still 1. Write CTRL=1 -> flag reasserts with ch=4.
- In SERVICE on ch1, a new irq_in[1] edge occurs -> PEND bit1=1, no flag until int_done. After done -> ch=1 again. The same-cycle W1C and edge case on bit6 -> bit6 stays 1.
- Assert rst during REQ -> on the next edge flag=0, PEND=0, MASK=0, STATUS=0. A spurious int_ack afterwards has no effect.
